alioth_timer: RTL and testbench
===============================

ALIOTH_TIMER -- requirements
Module: alioth_timer

Interface
- REQ-001 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
- REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
- REQ-003 SHALL have port: addr_i  input  32  register address; only addr_i[3:0] decoded.
- REQ-004 SHALL have port: data_i  input  32  write data.
- REQ-005 SHALL have port: we_i  input  1  write strobe, sampled on clk edge.
- REQ-006 SHALL have port: data_o  output  32  read data, combinational from addr_i, zero latency.
- REQ-007 SHALL have port: int_sig_o  output  1  interrupt, = CTRL.INT_PEND & CTRL.INT_EN, driven from registered bits only.

Function
- REQ-008 SHALL map registers: 0x0 CTRL (bit0 EN, bit1 INT_EN, bit2 INT_PEND, bit3 AUTO_RELOAD, other bits read 0); 0x4 COUNT (read-only); 0x8 VALUE (compare, R/W); 0xC PRESCALE (R/W, see Configuration).
- REQ-009 SHALL return 0 for unmapped offsets and ignore writes to them and to COUNT.
- REQ-010 SHALL implement a 2-state FSM: IDLE (EN=0, COUNT held) and RUN (EN=1); IDLE->RUN on CTRL write with EN=1, RUN->IDLE on CTRL write with EN=0 or on a one-shot match.
- REQ-011 SHALL clear COUNT and the prescale counter to 0 on the IDLE->RUN transition.
- REQ-012 SHALL, in RUN, increment COUNT by 1 on every tick (tick = every cycle when prescaling is absent).
- REQ-013 SHALL detect a match when a tick occurs with COUNT == VALUE and VALUE != 0; on match COUNT <= 0 and INT_PEND <= 1 in the same edge.
- REQ-014 SHALL, on match with AUTO_RELOAD=0, clear EN (return to IDLE); with AUTO_RELOAD=1, stay in RUN.
- REQ-015 SHALL hold COUNT at 0 and never match when VALUE == 0 in RUN.
- REQ-016 SHALL wrap COUNT from 0xFFFFFFFF to 0 when VALUE is rewritten below the current COUNT.
- REQ-017 SHALL clear INT_PEND by writing CTRL with bit2=1 (write-1-to-clear); writing bit2=0 leaves it unchanged.
- REQ-018 SHALL give the match set priority over a same-cycle W1C clear of INT_PEND.
- REQ-019 SHALL give a same-cycle CTRL write of EN=0 priority over a match's EN clear/retain (result EN=0, INT_PEND still set).
- REQ-020 SHALL apply a VALUE write from the next edge; the compare in the write cycle uses the old VALUE.

Reset
- REQ-021 SHALL, while rst=1 at a clk edge, set CTRL, COUNT, VALUE, PRESCALE and the prescale counter to 0 (int_sig_o=0, FSM=IDLE), aborting any run in progress.
- REQ-022 SHALL ignore we_i during reset cycles.

Configuration
- REQ-023 SHALL support macro ALIOTH_TIMER_PRESCALER_EN: defined -> PRESCALE register present, tick asserted once every PRESCALE+1 RUN cycles; undefined -> offset 0xC reads 0, writes ignored, tick every RUN cycle.

Structure
- REQ-024 SHALL place register offsets, CTRL bit positions and FSM state encodings in shared package alioth_timer_pkg.
- REQ-025 SHALL implement the prescale counter and tick generation as sub-module alioth_timer_prescaler (instantiated only when the macro is defined).

Verification
- REQ-026 SHALL cover one-shot: VALUE=5, CTRL=0x3 -> INT_PEND=1 and int_sig_o=1 on the 6th RUN tick, COUNT=0, EN=0.
- REQ-027 SHALL cover auto-reload: VALUE=3, CTRL=0xB -> match every 4 cycles, EN stays 1; W1C CTRL=0xF clears INT_PEND.
- REQ-028 SHALL cover W1C collision: clear written on the match edge -> INT_PEND remains 1.
- REQ-029 SHALL cover wrap: in RUN with COUNT=10, write VALUE=4 -> COUNT continues to 0xFFFFFFFF, wraps to 0, then matches at 4 (force COUNT for simulation time).
- REQ-030 SHALL cover prescale (macro on): PRESCALE=2, VALUE=2 -> match after 9 RUN cycles; macro off -> read 0xC returns 0.
- REQ-031 SHALL cover reset mid-run: rst asserted with COUNT=7 -> all registers 0, int_sig_o=0 next edge.

Source files
------------

// File: rtl/alioth_timer_pkg.sv
// rtl/alioth_timer_pkg.sv - shared register map, CTRL bit positions and FSM encoding
// Purpose : constants and types shared by alioth_timer and its prescaler.
// Contents: register offsets (addr_i[3:0]), CTRL bit indices, run-state enum.
package alioth_timer_pkg;

    localparam logic [3:0] ADDR_CTRL     = 4'h0;
    localparam logic [3:0] ADDR_COUNT    = 4'h4;
    localparam logic [3:0] ADDR_VALUE    = 4'h8;
    localparam logic [3:0] ADDR_PRESCALE = 4'hC;

    localparam int CTRL_EN          = 0;
    localparam int CTRL_INT_EN      = 1;
    localparam int CTRL_INT_PEND    = 2;
    localparam int CTRL_AUTO_RELOAD = 3;

    // CTRL.EN reads back as (state == ST_RUN); there is no separate EN flop.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/alioth_timer_prescaler.sv
// rtl/alioth_timer_prescaler.sv - prescale counter producing one tick per PRESCALE+1 run cycles
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   run_i             timer is in RUN; counter advances only then
//   start_i           IDLE->RUN transition; clears the counter
//   prescale_i[31:0]  divide value; tick every prescale_i+1 run cycles
//   tick_o            combinational tick for the current cycle
module alioth_timer_prescaler (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_i,
    input  logic        start_i,
    input  logic [31:0] prescale_i,
    output logic        tick_o
);

    logic [31:0] pcnt_q, pcnt_d;

    // >= rather than == so that lowering PRESCALE below the current count
    // produces a tick immediately instead of a 2^32-cycle stall.
    assign tick_o = run_i && (pcnt_q >= prescale_i);

    always_comb begin
        pcnt_d = pcnt_q;
        if (start_i) begin
            pcnt_d = '0;
        end else if (run_i) begin
            pcnt_d = tick_o ? '0 : pcnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/alioth_timer.sv
// rtl/alioth_timer.sv - register-mapped compare timer with one-shot/auto-reload and interrupt
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   addr_i[31:0]    register address, only [3:0] decoded
//   data_i[31:0]    write data
//   we_i            write strobe
//   data_o[31:0]    combinational read data for addr_i
//   int_sig_o       CTRL.INT_PEND & CTRL.INT_EN
// Build option: ALIOTH_TIMER_PRESCALER_EN adds the PRESCALE register and prescaler.
module alioth_timer
    import alioth_timer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic        we_i,
    output logic [31:0] data_o,
    output logic        int_sig_o
);

    state_e      state_q, state_d;
    logic        int_en_q, int_en_d;
    logic        pend_q, pend_d;
    logic        ar_q, ar_d;
    logic [31:0] count_q, count_d;
    logic [31:0] value_q, value_d;
    logic [31:0] prescale_rd;
    logic        tick;
    logic        match;
    logic        start;
    logic        wr_ctrl, wr_value;
    logic        unused_addr;

    assign unused_addr = ^addr_i[31:4];

    assign wr_ctrl  = we_i && (addr_i[3:0] == ADDR_CTRL);
    assign wr_value = we_i && (addr_i[3:0] == ADDR_VALUE);
    assign start    = wr_ctrl && data_i[CTRL_EN] && (state_q == ST_IDLE);

`ifdef ALIOTH_TIMER_PRESCALER_EN
    logic [31:0] prescale_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prescale_q <= '0;
        end else if (we_i && (addr_i[3:0] == ADDR_PRESCALE)) begin
            prescale_q <= data_i;
        end
    end

    assign prescale_rd = prescale_q;

    alioth_timer_prescaler u_prescaler (
        .clk        (clk),
        .rst        (rst),
        .run_i      (state_q == ST_RUN),
        .start_i    (start),
        .prescale_i (prescale_q),
        .tick_o     (tick)
    );
`else
    assign prescale_rd = '0;
    assign tick        = (state_q == ST_RUN);
`endif

    // Compare uses the registered VALUE, so a VALUE write only affects the next edge.
    assign match = tick && (value_q != '0) && (count_q == value_q);

    always_comb begin
        state_d  = state_q;
        int_en_d = int_en_q;
        pend_d   = pend_q;
        ar_d     = ar_q;
        count_d  = count_q;
        value_d  = value_q;

        if (state_q == ST_RUN) begin
            if (value_q == '0) begin
                count_d = '0;
            end else if (match) begin
                count_d = '0;
            end else if (tick) begin
                count_d = count_q + 32'd1;
            end
            if (match && !ar_q) begin
                state_d = ST_IDLE;
            end
        end

        if (match) begin
            pend_d = 1'b1;
        end

        // A CTRL write overrides the match's EN decision; the W1C clear loses to a match.
        if (wr_ctrl) begin
            state_d  = data_i[CTRL_EN] ? ST_RUN : ST_IDLE;
            int_en_d = data_i[CTRL_INT_EN];
            ar_d     = data_i[CTRL_AUTO_RELOAD];
            if (data_i[CTRL_INT_PEND] && !match) begin
                pend_d = 1'b0;
            end
        end

        if (start) begin
            count_d = '0;
        end

        if (wr_value) begin
            value_d = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            int_en_q <= 1'b0;
            pend_q   <= 1'b0;
            ar_q     <= 1'b0;
            count_q  <= '0;
            value_q  <= '0;
        end else begin
            state_q  <= state_d;
            int_en_q <= int_en_d;
            pend_q   <= pend_d;
            ar_q     <= ar_d;
            count_q  <= count_d;
            value_q  <= value_d;
        end
    end

    always_comb begin
        data_o = '0;
        case (addr_i[3:0])
            ADDR_CTRL: begin
                data_o[CTRL_EN]          = (state_q == ST_RUN);
                data_o[CTRL_INT_EN]      = int_en_q;
                data_o[CTRL_INT_PEND]    = pend_q;
                data_o[CTRL_AUTO_RELOAD] = ar_q;
            end
            ADDR_COUNT:    data_o = count_q;
            ADDR_VALUE:    data_o = value_q;
            ADDR_PRESCALE: data_o = prescale_rd;
            default:       data_o = '0;
        endcase
    end

    assign int_sig_o = pend_q & int_en_q;

endmodule

// File: tb/tb_alioth_timer.sv
// tb/tb_alioth_timer.sv - directed bench with per-cycle reference model for alioth_timer
module tb_alioth_timer;

    logic        clk;
    logic        rst;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic        we_i;
    logic [31:0] data_o;
    logic        int_sig_o;

    int n_checks = 0;
    int n_fail   = 0;

    alioth_timer dut (
        .clk       (clk),
        .rst       (rst),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .we_i      (we_i),
        .data_o    (data_o),
        .int_sig_o (int_sig_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: timer state held as plain integers, advanced once per edge.
    bit          m_valid = 0;
    bit          m_en, m_inten, m_pend, m_ar;
    logic [31:0] m_count, m_value, m_presc, m_pc;

`ifdef ALIOTH_TIMER_PRESCALER_EN
    localparam bit PRESC = 1'b1;
`else
    localparam bit PRESC = 1'b0;
`endif

    function automatic logic [31:0] m_read(input logic [3:0] a);
        case (a)
            4'h0:    return {28'd0, m_ar, m_pend, m_inten, m_en};
            4'h4:    return m_count;
            4'h8:    return m_value;
            4'hC:    return PRESC ? m_presc : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        bit fire, hit, was_en;
        if (rst) begin
            m_valid = 1;
            {m_en, m_inten, m_pend, m_ar} = 4'b0;
            m_count = 0; m_value = 0; m_presc = 0; m_pc = 0;
        end else if (m_valid) begin
            was_en = m_en;
            fire = m_en && (!PRESC || m_pc >= m_presc);
            hit  = fire && m_value != 0 && m_count == m_value;
            if (m_en) begin
                m_pc = fire ? 0 : m_pc + 1;
                if (m_value == 0 || hit) m_count = 0;
                else if (fire) m_count = m_count + 1;
            end
            if (hit) begin
                m_pend = 1;
                if (!m_ar) m_en = 0;
            end
            if (we_i) begin
                case (addr_i[3:0])
                    4'h0: begin
                        if (!was_en && data_i[0]) begin
                            m_count = 0;
                            m_pc    = 0;
                        end
                        m_en    = data_i[0];
                        m_inten = data_i[1];
                        m_ar    = data_i[3];
                        if (data_i[2] && !hit) m_pend = 0;
                    end
                    4'h8: m_value = data_i;
                    4'hC: if (PRESC) m_presc = data_i;
                    default: ;
                endcase
            end
        end
    end

    // Per-cycle compare of both outputs against the model.
    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            n_checks++;
            if (int_sig_o !== (m_pend & m_inten)) begin
                n_fail++;
                $display("FAIL cyc_int t=%0t actual=%0b expected=%0b", $time, int_sig_o, m_pend & m_inten);
            end
            n_checks++;
            if (data_o !== m_read(addr_i[3:0])) begin
                n_fail++;
                $display("FAIL cyc_data addr=%h t=%0t actual=%h expected=%h",
                         addr_i[3:0], $time, data_o, m_read(addr_i[3:0]));
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr_i = a; data_i = d; we_i = 1'b1;
        @(negedge clk);
        we_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr_i = a;
        #1;
        chk(name, data_o, exp);
    endtask

    task automatic chk_int(input string name, input logic exp);
        chk(name, {31'd0, int_sig_o}, {31'd0, exp});
    endtask

    initial begin
        rst = 1'b1; addr_i = 0; data_i = 0; we_i = 0;
        idle(2);
        rst = 1'b0;
        rd("rst_ctrl", 32'h0, 32'h0);
        rd("rst_count", 32'h4, 32'h0);
        rd("rst_value", 32'h8, 32'h0);
        chk_int("rst_int", 1'b0);

        // One-shot VALUE=5: match on the 6th run edge.
        wr(32'h8, 32'd5);
        wr(32'h0, 32'h3);
        addr_i = 32'h4;
        idle(5);
        rd("os_count5", 32'h4, 32'd5);
        chk_int("os_int_before", 1'b0);
        idle(1);
        rd("os_count0", 32'h4, 32'd0);
        rd("os_ctrl", 32'h0, 32'h6);
        chk_int("os_int", 1'b1);
        addr_i = 32'h4;
        idle(3);
        rd("os_held", 32'h4, 32'd0);
        wr(32'h4, 32'd123);
        rd("count_ro", 32'h4, 32'd0);
        rd("unmapped", 32'h2, 32'd0);

        // W1C clear, then auto-reload VALUE=3.
        wr(32'h0, 32'h4);
        rd("w1c_ctrl", 32'h0, 32'h0);
        wr(32'h8, 32'd3);
        wr(32'h0, 32'hB);
        addr_i = 32'h4;
        idle(3);
        rd("ar_count3", 32'h4, 32'd3);
        idle(1);
        rd("ar_count0", 32'h4, 32'd0);
        rd("ar_ctrl", 32'h0, 32'hF);
        wr(32'h0, 32'hF);
        rd("ar_w1c", 32'h0, 32'hB);
        rd("ar_count1", 32'h4, 32'd1);

        // W1C on the match edge: INT_PEND stays set.
        addr_i = 32'h4;
        idle(2);
        rd("col_count3", 32'h4, 32'd3);
        wr(32'h0, 32'hF);
        rd("col_ctrl", 32'h0, 32'hF);

        // EN=0 write on the match edge wins; INT_PEND still set.
        wr(32'h0, 32'hF);
        addr_i = 32'h4;
        idle(2);
        wr(32'h0, 32'h2);
        rd("en0_ctrl", 32'h0, 32'h6);
        rd("en0_count", 32'h4, 32'd0);

        // Wrap: VALUE lowered under COUNT, COUNT forced near the top.
        wr(32'h0, 32'h4);
        wr(32'h8, 32'd100);
        wr(32'h0, 32'h3);
        addr_i = 32'h4;
        idle(10);
        rd("wr_count10", 32'h4, 32'd10);
        wr(32'h8, 32'd4);
        rd("wr_oldval", 32'h4, 32'd11);
        force dut.count_q = 32'hFFFF_FFFD;
        m_count = 32'hFFFF_FFFD;
        #1;
        release dut.count_q;
        idle(2);
        rd("wr_top", 32'h4, 32'hFFFF_FFFF);
        idle(1);
        rd("wr_zero", 32'h4, 32'd0);
        idle(4);
        rd("wr_four", 32'h4, 32'd4);
        rd("wr_run", 32'h0, 32'h3);
        idle(1);
        rd("wr_match_cnt", 32'h4, 32'd0);
        rd("wr_match_ctrl", 32'h0, 32'h6);
        chk_int("wr_int", 1'b1);

        // VALUE=0 in RUN: COUNT pinned at 0, never matches.
        wr(32'h0, 32'h4);
        wr(32'h8, 32'd0);
        wr(32'h0, 32'h1);
        addr_i = 32'h4;
        idle(5);
        rd("v0_count", 32'h4, 32'd0);
        rd("v0_ctrl", 32'h0, 32'h1);
        wr(32'h0, 32'h0);

`ifdef ALIOTH_TIMER_PRESCALER_EN
        wr(32'hC, 32'd2);
        wr(32'h8, 32'd2);
        wr(32'h0, 32'h3);
        addr_i = 32'h4;
        idle(8);
        rd("ps_count2", 32'h4, 32'd2);
        rd("ps_ctrl_run", 32'h0, 32'h3);
        idle(1);
        rd("ps_count0", 32'h4, 32'd0);
        rd("ps_ctrl", 32'h0, 32'h6);
        rd("ps_reg", 32'hC, 32'd2);
`else
        wr(32'hC, 32'd5);
        rd("ps_absent", 32'hC, 32'd0);
`endif

        // Reset mid-run with COUNT=7 and a concurrent write attempt.
        wr(32'h0, 32'h4);
        wr(32'h8, 32'd20);
        wr(32'h0, 32'h3);
        addr_i = 32'h4;
        idle(7);
        rd("mr_count7", 32'h4, 32'd7);
        rst = 1'b1; addr_i = 32'h8; data_i = 32'd55; we_i = 1'b1;
        @(negedge clk);
        rst = 1'b0; we_i = 1'b0;
        rd("mr_ctrl", 32'h0, 32'h0);
        rd("mr_count", 32'h4, 32'h0);
        rd("mr_value", 32'h8, 32'h0);
        rd("mr_presc", 32'hC, 32'h0);
        chk_int("mr_int", 1'b0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
